// File: rtl/lfsr_stream_gen.sv
// Fibonacci LFSR block generator: seeds, scrambles for SHIFT_CYCLES shifts,
// then serialises the WIDTH-bit word LSB-first with a start/busy/done handshake.
module lfsr_stream_gen #(
   parameter int unsigned      WIDTH        = 4,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(4'b1001),
   parameter int unsigned      SHIFT_CYCLES = 8,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(4'b0001)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic             continuous,
   output logic             OUT,
   output logic             Valid,
   output logic             busy,
   output logic             done,
   output logic             seed_fixed
);

   localparam int unsigned CNT_MAX = (SHIFT_CYCLES > WIDTH) ? SHIFT_CYCLES : WIDTH;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, SERIAL, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] lfsr, lfsr_step, ser;
   logic [CW-1:0]    cnt;
   logic             shift_last, bits_last, seed_zero;

   assign lfsr_step  = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
   assign shift_last = (cnt == CW'(SHIFT_CYCLES - 1));
   assign bits_last  = (cnt == CW'(WIDTH - 1));
   assign seed_zero  = (seed == '0);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = SHIFT;
         SHIFT:   if (shift_last) state_n = SERIAL;
         SERIAL:  if (bits_last) state_n = DONE;
         DONE:    state_n = continuous ? SHIFT : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The serialiser drains to zero after WIDTH shifts, so OUT needs no gating.
   always_ff @(posedge CLK) begin
      if (RST) begin
         lfsr       <= '0;
         ser        <= '0;
         cnt        <= '0;
         seed_fixed <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr       <= seed_zero ? DEFAULT_SEED : seed;
                  seed_fixed <= seed_zero;
                  cnt        <= '0;
               end
            end
            SHIFT: begin
               lfsr <= lfsr_step;
               if (shift_last) begin
                  ser <= lfsr_step;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SERIAL: begin
               ser <= ser >> 1;
               cnt <= bits_last ? '0 : cnt + CW'(1);
            end
            DONE:    cnt <= '0;
            default: cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         Valid <= (state_n == SERIAL);
         busy  <= (state_n != IDLE);
         done  <= (state_n == DONE);
      end
   end

   assign OUT = ser[0];

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench for lfsr_stream_gen: cycle timeline model plus directed scenarios
// and a maximal-length period check on a second instance with one shift per block.
module tb_lfsr_stream_gen;

   localparam int          W   = 4;
   localparam int          SC  = 8;
   localparam logic [W-1:0] TAP = 4'b1001;
   localparam logic [W-1:0] DEF = 4'b0001;
   localparam int          N   = 4096;

   logic         clk = 1'b0;
   logic         rst, start, cont;
   logic [W-1:0] seed;
   logic         out, valid, busy, done, sf;
   logic         rst2, start2, cont2;
   logic [W-1:0] seed2;
   logic         out2, valid2, busy2, done2, sf2;

   int total = 0;
   int bad   = 0;

   lfsr_stream_gen #(.WIDTH(W), .TAPS(TAP), .SHIFT_CYCLES(SC), .DEFAULT_SEED(DEF)) dut (
      .CLK(clk), .RST(rst), .start(start), .seed(seed), .continuous(cont),
      .OUT(out), .Valid(valid), .busy(busy), .done(done), .seed_fixed(sf));

   lfsr_stream_gen #(.WIDTH(W), .TAPS(TAP), .SHIFT_CYCLES(1), .DEFAULT_SEED(DEF)) dut2 (
      .CLK(clk), .RST(rst2), .start(start2), .seed(seed2), .continuous(cont2),
      .OUT(out2), .Valid(valid2), .busy(busy2), .done(done2), .seed_fixed(sf2));

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // n applications of the Fibonacci rule: new MSB = XOR of tapped bits, rest shift down
   function automatic logic [W-1:0] advance(input logic [W-1:0] s, input int n);
      logic [W-1:0] v;
      logic         fb;
      v = s;
      for (int j = 0; j < n; j++) begin
         fb = 1'b0;
         for (int i = 0; i < W; i++) if (TAP[i]) fb = fb ^ v[i];
         v = {fb, v[W-1:1]};
      end
      return v;
   endfunction

   // Expected outputs indexed by cycle (cycle e = interval after the e-th rising edge)
   bit           exp_busy [N];
   bit           exp_valid[N];
   bit           exp_out  [N];
   bit           exp_done [N];
   bit           exp_sf   [N];
   int           e      = 0;
   logic [W-1:0] m_lfsr = '0;
   bit           m_sf   = 1'b0;
   bit           chk_en = 1'b0;

   // A block accepted at edge k: SC shift cycles, W valid cycles, one done cycle
   task automatic schedule(input int k);
      m_lfsr = advance(m_lfsr, SC);
      for (int c = k; c <= k + SC + W; c++) if (c < N) exp_busy[c] = 1'b1;
      for (int b = 0; b < W; b++) begin
         if (k + SC + b < N) begin
            exp_valid[k + SC + b] = 1'b1;
            exp_out[k + SC + b]   = m_lfsr[b];
         end
      end
      if (k + SC + W < N) exp_done[k + SC + W] = 1'b1;
   endtask

   initial forever begin
      @(posedge clk);
      e = e + 1;
      if (e < N) begin
         if (rst) begin
            for (int c = e; c < N; c++) begin
               exp_busy[c] = 1'b0; exp_valid[c] = 1'b0; exp_out[c] = 1'b0; exp_done[c] = 1'b0;
            end
            m_sf = 1'b0;
         end else if (!exp_busy[e-1] && start) begin
            m_sf   = (seed == '0);
            m_lfsr = m_sf ? DEF : seed;
            schedule(e);
         end else if (exp_done[e-1] && cont) begin
            schedule(e);
         end
         exp_sf[e] = m_sf;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en && e < N) begin
         check("cyc_valid", 32'(valid), 32'(exp_valid[e]));
         check("cyc_out",   32'(out),   32'(exp_out[e]));
         check("cyc_busy",  32'(busy),  32'(exp_busy[e]));
         check("cyc_done",  32'(done),  32'(exp_done[e]));
         check("cyc_sf",    32'(sf),    32'(exp_sf[e]));
      end
   end

   task automatic get_word(output logic [W-1:0] w, output int g);
      w = '0;
      g = 0;
      while (valid !== 1'b1 && g < 200) begin
         g++;
         @(negedge clk);
      end
      if (valid !== 1'b1) begin
         check("valid_timeout", 32'(0), 32'(1));
         return;
      end
      for (int b = 0; b < W; b++) begin
         w[b] = out;
         @(negedge clk);
      end
   endtask

   task automatic get_word2(output logic [W-1:0] w);
      int g;
      w = '0;
      g = 0;
      while (valid2 !== 1'b1 && g < 200) begin
         g++;
         @(negedge clk);
      end
      if (valid2 !== 1'b1) begin
         check("valid2_timeout", 32'(0), 32'(1));
         return;
      end
      for (int b = 0; b < W; b++) begin
         w[b] = out2;
         @(negedge clk);
      end
   endtask

   task automatic pulse_start(input logic [W-1:0] s);
      seed  = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [W-1:0] w, w4;
   int           g, g4, ndist;
   logic [W-1:0] pw[15];
   bit           seen[16];

   initial begin
      rst = 1'b1; start = 1'b0; cont = 1'b0; seed = '0;
      rst2 = 1'b1; start2 = 1'b0; cont2 = 1'b0; seed2 = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_valid", 32'(valid), 32'(0));
      check("rst_sf", 32'(sf), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // Hand-derived words pin the model's feedback rule
      check("pin_blk1", 32'(advance(4'b1001, SC)), 32'(4'b0111));
      check("pin_blk2", 32'(advance(4'b0111, SC)), 32'(4'b0100));

      // Single block from seed 1001
      pulse_start(4'b1001);
      get_word(w, g);
      check("s1_gap", 32'(g), 32'(SC));
      check("s1_word", 32'(w), 32'(4'b0111));
      check("s1_done", 32'(done), 32'(1));
      @(negedge clk);
      check("s1_idle", 32'(busy), 32'(0));
      check("s1_sf", 32'(sf), 32'(0));

      // Two chained blocks, continuous dropped during the second
      cont = 1'b1;
      pulse_start(4'b1001);
      get_word(w, g);
      check("s2_word1", 32'(w), 32'(4'b0111));
      check("s2_done1", 32'(done), 32'(1));
      @(negedge clk);
      cont = 1'b0;
      check("s2_chained", 32'(busy), 32'(1));
      get_word(w, g);
      check("s2_gap", 32'(g + 1), 32'(SC + 1));
      check("s2_word2", 32'(w), 32'(4'b0100));
      check("s2_done2", 32'(done), 32'(1));
      @(negedge clk);
      check("s2_idle", 32'(busy), 32'(0));

      // Zero seed is replaced by the default and flagged
      pulse_start(4'b0000);
      check("s3_sf_set", 32'(sf), 32'(1));
      get_word(w, g);
      check("s3_word", 32'(w), 32'(4'b1010));
      @(negedge clk);
      pulse_start(4'b0011);
      check("s3_sf_clr", 32'(sf), 32'(0));
      get_word(w, g);
      check("s3_word2", 32'(w), 32'(4'b1111));
      @(negedge clk);

      // start and seed churn while busy, start high during the done cycle
      pulse_start(4'b1001);
      fork
         begin
            get_word(w4, g4);
            check("s4_done", 32'(done), 32'(1));
         end
         begin
            for (int i = 0; i <= 12; i++) begin
               start = (i % 2 == 0) || (i == 12);
               seed  = W'(i * 3 + 2);
               @(negedge clk);
            end
            start = 1'b0;
         end
      join
      check("s4_word", 32'(w4), 32'(4'b0111));
      check("s4_idle", 32'(busy), 32'(0));
      repeat (15) @(negedge clk);
      check("s4_no_extra", 32'(busy), 32'(0));

      // Reset during the second serial bit aborts the block
      pulse_start(4'b1001);
      g = 0;
      while (valid !== 1'b1 && g < 200) begin
         g++;
         @(negedge clk);
      end
      check("s5_reached_serial", 32'(valid), 32'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("s5_busy", 32'(busy), 32'(0));
      check("s5_valid", 32'(valid), 32'(0));
      check("s5_out", 32'(out), 32'(0));
      check("s5_done", 32'(done), 32'(0));
      repeat (12) @(negedge clk);
      check("s5_stays_idle", 32'(busy), 32'(0));
      pulse_start(4'b1001);
      get_word(w, g);
      check("s5_word", 32'(w), 32'(4'b0111));
      check("s5_gap", 32'(g), 32'(SC));
      @(negedge clk);

      // Period of the 4-bit tap set with one shift per block
      rst2 = 1'b0;
      @(negedge clk);
      cont2 = 1'b1;
      seed2 = 4'b1001;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         get_word2(pw[i]);
         if (i == 14) begin
            check("p_done", 32'(done2), 32'(1));
            cont2 = 1'b0;
         end
      end
      @(negedge clk);
      check("p_idle", 32'(busy2), 32'(0));
      check("p_sf", 32'(sf2), 32'(0));
      check("p_first", 32'(pw[0]), 32'(4'b0100));
      check("p_last", 32'(pw[14]), 32'(4'b1001));
      ndist = 0;
      for (int i = 0; i < 16; i++) seen[i] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check("p_model", 32'(pw[i]), 32'(advance(4'b1001, i + 1)));
         if (!seen[pw[i]] && pw[i] != '0) ndist++;
         seen[pw[i]] = 1'b1;
      end
      check("p_distinct", 32'(ndist), 32'(15));
      check("p_no_zero", 32'(seen[0]), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
